// File: rtl/protocore_dbg_pkg.sv
// Shared definitions for the register-file debug port: op codes, FSM states and default widths
// reused wherever reg_file and reg_dbg_port are wired together.
package protocore_dbg_pkg;

    localparam int RF_DATA_W   = 8;
    localparam int RF_ADDR_W   = 4;
    localparam int RF_NUM_REGS = 1 << RF_ADDR_W;

    localparam logic [1:0] OP_RD   = 2'b00;
    localparam logic [1:0] OP_WR   = 2'b01;
    localparam logic [1:0] OP_DUMP = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_DUMP,
        ST_RESP
    } dbg_state_t;

endpackage

// File: rtl/reg_dbg_port.sv
// Debug initiator for the 16x8 register file: read/write/dump commands in, one response per register out.
// Define REG_DBG_DUMP_EN to enable the dump walk; otherwise op 10 is answered as an illegal op.
module reg_dbg_port
    import protocore_dbg_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_REGS = RF_NUM_REGS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    input  logic [ADDR_W-1:0] core_ra,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_wa,
    input  logic [DATA_W-1:0] core_wd,
    output logic              core_stall,
    output logic [ADDR_W-1:0] rf_ra,
    input  logic [DATA_W-1:0] rf_read_a,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_wa,
    output logic [DATA_W-1:0] rf_wd
);

    if (NUM_REGS > (1 << ADDR_W)) begin : g_bad_num_regs
        $error("NUM_REGS exceeds the register address space");
    end

    dbg_state_t        state;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] capture_addr;
    logic [DATA_W-1:0] capture_data;
    logic              dbg_we;

`ifdef REG_DBG_DUMP_EN
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    logic [ADDR_W-1:0] dump_idx;
    logic              dump_active;

    assign capture_addr = (state == ST_DUMP) ? dump_idx : addr_q;
`else
    assign capture_addr = addr_q;
`endif

    assign cmd_ready    = (state == ST_IDLE) && !rst;
    assign core_stall   = (state == ST_READ) || (state == ST_DUMP);
    assign rf_ra        = core_stall ? capture_addr : core_ra;
    assign capture_data = (capture_addr == '0) ? '0 : rf_read_a;

    // The core always wins the write port; a debug write only goes out on a cycle the core leaves free.
    assign dbg_we = (state == ST_WRITE) && !core_we && (addr_q != '0);
    assign rf_we  = core_we || dbg_we;
    assign rf_wa  = core_we ? core_wa : addr_q;
    assign rf_wd  = core_we ? core_wd : data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            rsp_addr  <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
`ifdef REG_DBG_DUMP_EN
            dump_idx    <= '0;
            dump_active <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        addr_q <= cmd_addr;
                        data_q <= cmd_data;
                        case (cmd_op)
                            OP_RD: state <= ST_READ;
                            OP_WR: state <= ST_WRITE;
`ifdef REG_DBG_DUMP_EN
                            OP_DUMP: begin
                                dump_active <= 1'b1;
                                dump_idx    <= '0;
                                state       <= ST_DUMP;
                            end
`endif
                            default: begin
                                rsp_valid <= 1'b1;
                                rsp_addr  <= cmd_addr;
                                rsp_data  <= '0;
                                rsp_err   <= 1'b1;
                                state     <= ST_RESP;
                            end
                        endcase
                    end
                end
                ST_READ, ST_DUMP: begin
                    rsp_valid <= 1'b1;
                    rsp_addr  <= capture_addr;
                    rsp_data  <= capture_data;
                    rsp_err   <= 1'b0;
                    state     <= ST_RESP;
                end
                ST_WRITE: begin
                    if ((addr_q == '0) || !core_we) begin
                        rsp_valid <= 1'b1;
                        rsp_addr  <= addr_q;
                        rsp_data  <= data_q;
                        rsp_err   <= (addr_q == '0);
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
`ifdef REG_DBG_DUMP_EN
                        if (dump_active && (dump_idx != LAST_IDX)) begin
                            dump_idx <= dump_idx + ADDR_W'(1);
                            state    <= ST_DUMP;
                        end else begin
                            dump_active <= 1'b0;
                            dump_idx    <= '0;
                            state       <= ST_IDLE;
                        end
`else
                        state <= ST_IDLE;
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
